// File: rtl/aud_pkg.sv
// Shared types, constants and helpers for the audio session controller.
package aud_pkg;

  localparam int unsigned AUD_ADDR_W = 20;
  localparam int unsigned AUD_DATA_W = 16;
  localparam logic [AUD_ADDR_W-1:0] AUD_MAX_ADDR = 20'hFFFFF;

  // Codes are visible on o_state and must stay fixed.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REC        = 3'd1,
    ST_REC_PAUSE  = 3'd2,
    ST_PLAY       = 3'd3,
    ST_PLAY_PAUSE = 3'd4
  } state_e;

  // How the SRAM mux should treat the port in the current session state.
  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_REC,
    MODE_TRACK,
    MODE_PLAY
  } mode_e;

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_STOP,
    KEY_PAUSE,
    KEY_REC,
    KEY_PLAY
  } key_e;

  typedef struct packed {
    logic rec_start;
    logic rec_pause;
    logic rec_stop;
    logic play_start;
    logic play_pause;
    logic play_stop;
  } cmd_t;

  // Only the highest-ranked key is acted on; the state then decides whether it matters.
  function automatic key_e key_winner(input logic stop, input logic pause,
                                      input logic rec, input logic play);
    if (stop)       return KEY_STOP;
    else if (pause) return KEY_PAUSE;
    else if (rec)   return KEY_REC;
    else if (play)  return KEY_PLAY;
    else            return KEY_NONE;
  endfunction

  function automatic mode_e state_mode(input state_e st);
    case (st)
      ST_REC:                 return MODE_REC;
      ST_REC_PAUSE:           return MODE_TRACK;
      ST_PLAY, ST_PLAY_PAUSE: return MODE_PLAY;
      default:                return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/aud_session_ctrl_if.sv
// Single-port asynchronous SRAM bus shared by the recorder and the player.
interface aud_session_ctrl_if
  import aud_pkg::*;
#(
  parameter int unsigned ADDR_W = AUD_ADDR_W,
  parameter int unsigned DATA_W = AUD_DATA_W
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we_n;
  logic              oe_n;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, output wdata, output we_n, output oe_n, input rdata);
  modport slave  (input addr, input wdata, input we_n, input oe_n, output rdata);

endinterface

// File: rtl/aud_sram_mux.sv
// Owns the SRAM port: recorder address-change detection, the one-cycle write
// strobe, end-of-recording pointer and the address/oe/we multiplexing.
module aud_sram_mux
  import aud_pkg::*;
#(
  parameter int unsigned       ADDR_W   = AUD_ADDR_W,
  parameter int unsigned       DATA_W   = AUD_DATA_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(AUD_MAX_ADDR)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  mode_e             mode,
  input  logic              rec_load,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic [DATA_W-1:0] rec_data,
  input  logic [ADDR_W-1:0] play_addr,
  output logic              wr_full,
  output logic [ADDR_W-1:0] end_addr,
  aud_session_ctrl_if.master sram
);

  logic [ADDR_W-1:0] rec_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] end_addr_q;
  logic              wr_stb_q;
  logic              wr_hit;
  logic              play_mode;

  // A recorder address step means the word at the old address is complete.
  assign wr_hit    = (mode == MODE_REC) && (rec_addr != rec_addr_q);
  assign wr_full   = wr_hit && (rec_addr_q == MAX_ADDR);
  assign play_mode = (mode == MODE_PLAY);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rec_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      end_addr_q <= '0;
      wr_stb_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      wr_stb_q <= wr_hit;
      if (wr_hit) begin
        wr_addr_q  <= rec_addr_q;
        wr_data_q  <= rec_data;
        end_addr_q <= rec_addr_q;
      end else if (rec_load) begin
        end_addr_q <= '0;
      end
      if (rec_load || wr_hit || (mode == MODE_TRACK)) begin
        rec_addr_q <= rec_addr;
      end
    end
  end

  assign end_addr   = end_addr_q;
  assign sram.wdata = wr_data_q;
  assign sram.we_n  = ~wr_stb_q;
  // A strobe and a read mode never overlap; gating oe_n on the strobe keeps that structural.
  assign sram.oe_n  = ~(play_mode && !wr_stb_q);
  assign sram.addr  = play_mode ? play_addr :
                      wr_stb_q  ? wr_addr_q : '0;

endmodule

// File: rtl/aud_session_ctrl.sv
// Session FSM for the audio lab: sequences recorder and player from key pulses
// and hands SRAM port ownership to aud_sram_mux.
module aud_session_ctrl
  import aud_pkg::*;
#(
  parameter int unsigned       ADDR_W   = AUD_ADDR_W,
  parameter int unsigned       DATA_W   = AUD_DATA_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(AUD_MAX_ADDR)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  input  logic [ADDR_W-1:0] i_play_addr,
  aud_session_ctrl_if.master sram,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  output logic [DATA_W-1:0] o_play_data,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic [2:0]        o_state
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  key_e              key;
  logic              rec_load;
  logic              wr_full;
  logic [ADDR_W-1:0] end_addr;
  logic [DATA_W-1:0] play_data_q;

  assign key = key_winner(i_key_stop, i_key_pause, i_key_rec, i_key_play);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      play_data_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      if (state_q == ST_PLAY) begin
        play_data_q <= sram.rdata;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d  = state_q;
    cmd_d    = '0;
    rec_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key == KEY_REC) begin
          state_d         = ST_REC;
          cmd_d.rec_start = 1'b1;
          rec_load        = 1'b1;
        end else if ((key == KEY_PLAY) && (end_addr != '0)) begin
          state_d          = ST_PLAY;
          cmd_d.play_start = 1'b1;
        end
      end
      ST_REC: begin
        // Filling the last word ends the session just like a stop key.
        if ((key == KEY_STOP) || wr_full) begin
          state_d        = ST_IDLE;
          cmd_d.rec_stop = 1'b1;
        end else if (key == KEY_PAUSE) begin
          state_d         = ST_REC_PAUSE;
          cmd_d.rec_pause = 1'b1;
        end
      end
      ST_REC_PAUSE: begin
        if (key == KEY_STOP) begin
          state_d        = ST_IDLE;
          cmd_d.rec_stop = 1'b1;
        end else if (key == KEY_REC) begin
          state_d         = ST_REC;
          cmd_d.rec_start = 1'b1;
        end
      end
      ST_PLAY: begin
        if ((key == KEY_STOP) || (i_play_addr >= end_addr)) begin
          state_d         = ST_IDLE;
          cmd_d.play_stop = 1'b1;
        end else if (key == KEY_PAUSE) begin
          state_d          = ST_PLAY_PAUSE;
          cmd_d.play_pause = 1'b1;
        end
      end
      ST_PLAY_PAUSE: begin
        if (key == KEY_STOP) begin
          state_d         = ST_IDLE;
          cmd_d.play_stop = 1'b1;
        end else if (key == KEY_PLAY) begin
          state_d          = ST_PLAY;
          cmd_d.play_start = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  aud_sram_mux #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_ADDR (MAX_ADDR)
  ) u_sram_mux (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .mode      (state_mode(state_q)),
    .rec_load  (rec_load),
    .rec_addr  (i_rec_addr),
    .rec_data  (i_rec_data),
    .play_addr (i_play_addr),
    .wr_full   (wr_full),
    .end_addr  (end_addr),
    .sram      (sram)
  );

  assign o_rec_start  = cmd_q.rec_start;
  assign o_rec_pause  = cmd_q.rec_pause;
  assign o_rec_stop   = cmd_q.rec_stop;
  assign o_play_start = cmd_q.play_start;
  assign o_play_pause = cmd_q.play_pause;
  assign o_play_stop  = cmd_q.play_stop;
  assign o_play_data  = play_data_q;
  assign o_end_addr   = end_addr;
  assign o_state      = state_q;

endmodule

// File: tb/tb_aud_session_ctrl.sv
// Directed scenarios plus randomized key/address traffic for aud_session_ctrl,
// compared every cycle against a behavioural session model with a write scoreboard.
module tb_aud_session_ctrl;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam logic [AW-1:0] MAX_A = 20'hFFFFF;

  localparam int S_IDLE = 0, S_REC = 1, S_RP = 2, S_PLAY = 3, S_PP = 4;

  // Key vector order {stop, pause, rec, play}.
  localparam logic [3:0] K_NONE = 4'b0000, K_STOP = 4'b1000, K_PAUSE = 4'b0100,
                         K_REC  = 4'b0010, K_PLAY = 4'b0001;
  // Pulse vector order {rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop}.
  localparam logic [5:0] P_RSTART = 6'b100000, P_RPAUSE = 6'b010000, P_RSTOP = 6'b001000,
                         P_PSTART = 6'b000100, P_PPAUSE = 6'b000010, P_PSTOP = 6'b000001;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          key_rec, key_play, key_pause, key_stop;
  logic [AW-1:0] rec_addr, play_addr, end_addr;
  logic [DW-1:0] rec_data, play_data;
  logic          rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop;
  logic [2:0]    state;
  logic [5:0]    pulses;

  aud_session_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) sram_bus ();

  aud_session_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(MAX_A)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_key_rec    (key_rec),
    .i_key_play   (key_play),
    .i_key_pause  (key_pause),
    .i_key_stop   (key_stop),
    .i_rec_addr   (rec_addr),
    .i_rec_data   (rec_data),
    .i_play_addr  (play_addr),
    .sram         (sram_bus),
    .o_rec_start  (rec_start),
    .o_rec_pause  (rec_pause),
    .o_rec_stop   (rec_stop),
    .o_play_start (play_start),
    .o_play_pause (play_pause),
    .o_play_stop  (play_stop),
    .o_play_data  (play_data),
    .o_end_addr   (end_addr),
    .o_state      (state)
  );

  assign pulses = {rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop};

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural session model: what the outputs should show in the current cycle.
  int                   m_state;
  logic [AW-1:0]        m_end, m_recq;
  logic [DW-1:0]        m_pdata;
  logic [5:0]           m_pulses;
  logic [AW+DW-1:0]     wq[$];   // writes due on the SRAM port, {addr, data}

  task automatic model_reset();
    m_state  = S_IDLE;
    m_end    = '0;
    m_recq   = '0;
    m_pdata  = '0;
    m_pulses = '0;
    wq.delete();
  endtask

  task automatic model_advance(input logic [3:0] keys);
    logic [3:0] win;
    logic       hit, full;
    logic [5:0] p;
    int         ns;
    win  = keys[3] ? K_STOP : keys[2] ? K_PAUSE : keys[1] ? K_REC : keys[0] ? K_PLAY : K_NONE;
    hit  = (m_state == S_REC) && (rec_addr != m_recq);
    full = hit && (m_recq == MAX_A);
    p    = '0;
    ns   = m_state;
    case (m_state)
      S_IDLE: if (win == K_REC) begin ns = S_REC; p = P_RSTART; end
              else if (win == K_PLAY && m_end != '0) begin ns = S_PLAY; p = P_PSTART; end
      S_REC:  if (win == K_STOP || full) begin ns = S_IDLE; p = P_RSTOP; end
              else if (win == K_PAUSE) begin ns = S_RP; p = P_RPAUSE; end
      S_RP:   if (win == K_STOP) begin ns = S_IDLE; p = P_RSTOP; end
              else if (win == K_REC) begin ns = S_REC; p = P_RSTART; end
      S_PLAY: if (win == K_STOP || play_addr >= m_end) begin ns = S_IDLE; p = P_PSTOP; end
              else if (win == K_PAUSE) begin ns = S_PP; p = P_PPAUSE; end
      S_PP:   if (win == K_STOP) begin ns = S_IDLE; p = P_PSTOP; end
              else if (win == K_PLAY) begin ns = S_PLAY; p = P_PSTART; end
      default: ;
    endcase
    if (m_state == S_PLAY) m_pdata = sram_bus.rdata;
    if (hit) begin
      wq.push_back({m_recq, rec_data});
      m_end  = m_recq;
      m_recq = rec_addr;
    end else if (m_state == S_RP) begin
      m_recq = rec_addr;
    end else if (m_state == S_IDLE && ns == S_REC) begin
      m_end  = '0;
      m_recq = rec_addr;
    end
    m_state  = ns;
    m_pulses = p;
  endtask

  // One clock cycle: drive keys, compare all outputs with the model, then clock.
  task automatic tick(input logic [3:0] keys);
    logic [AW+DW-1:0] wr;
    logic [AW-1:0]    exp_addr;
    logic             playing;
    {key_stop, key_pause, key_rec, key_play} = keys;
    #1;
    playing = (m_state == S_PLAY) || (m_state == S_PP);
    check("state", state, m_state);
    check("pulses", pulses, m_pulses);
    check("end_addr", end_addr, m_end);
    check("play_data", play_data, m_pdata);
    check("oe_n", sram_bus.oe_n, !playing);
    check("excl", sram_bus.we_n | sram_bus.oe_n, 1);
    if (wq.size() > 0) begin
      wr = wq.pop_front();
      check("we_n", sram_bus.we_n, 0);
      check("wr_data", sram_bus.wdata, wr[DW-1:0]);
      exp_addr = wr[AW+DW-1:DW];
    end else begin
      check("we_n", sram_bus.we_n, 1);
      exp_addr = playing ? play_addr : '0;
    end
    check("sram_addr", sram_bus.addr, exp_addr);
    model_advance(keys);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [3:0] k;
    int         r;
    i_rst = 1'b1;
    {key_stop, key_pause, key_rec, key_play} = K_NONE;
    rec_addr = '0; rec_data = '0; play_addr = '0; sram_bus.rdata = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    check("rst_state", state, S_IDLE);
    check("rst_pulses", pulses, 0);
    check("rst_we_n", sram_bus.we_n, 1);
    check("rst_oe_n", sram_bus.oe_n, 1);
    check("rst_addr", sram_bus.addr, 0);
    check("rst_wdata", sram_bus.wdata, 0);
    check("rst_pdata", play_data, 0);
    check("rst_end", end_addr, 0);

    // Play with nothing recorded is ignored.
    tick(K_PLAY);
    check("noplay_start", play_start, 0);
    check("noplay_state", state, S_IDLE);

    // Two-word recording.
    rec_addr = 20'd0;
    tick(K_REC);
    check("t1_rec_start", rec_start, 1);
    rec_addr = 20'd1; rec_data = 16'hA5A5;
    tick(K_NONE);
    check("t1_we0", sram_bus.we_n, 0);
    check("t1_wa0", sram_bus.addr, 0);
    check("t1_wd0", sram_bus.wdata, 16'hA5A5);
    rec_addr = 20'd2; rec_data = 16'h1234;
    tick(K_NONE);
    check("t1_we1", sram_bus.we_n, 0);
    check("t1_wa1", sram_bus.addr, 1);
    check("t1_wd1", sram_bus.wdata, 16'h1234);
    tick(K_STOP);
    check("t1_rec_stop", rec_stop, 1);
    check("t1_end", end_addr, 1);
    check("t1_state", state, S_IDLE);
    check("t1_we_idle", sram_bus.we_n, 1);

    // Playback runs until the end pointer.
    play_addr = 20'd0;
    tick(K_PLAY);
    check("t2_play_start", play_start, 1);
    check("t2_oe", sram_bus.oe_n, 0);
    play_addr = 20'd1;
    tick(K_NONE);
    check("t2_play_stop", play_stop, 1);
    check("t2_state", state, S_IDLE);

    // Pause+stop together, tracking while paused, stop colliding with a write.
    rec_addr = 20'd5;
    tick(K_REC);
    tick(K_STOP | K_PAUSE);
    check("t3_only_stop", pulses, P_RSTOP);
    tick(K_REC);
    tick(K_PAUSE);
    check("t3_paused", state, S_RP);
    rec_addr = 20'd6;
    tick(K_NONE);
    check("t3_no_write", sram_bus.we_n, 1);
    tick(K_NONE);
    tick(K_REC);
    check("t3_resume", rec_start, 1);
    check("t3_resume_st", state, S_REC);
    rec_addr = 20'd7; rec_data = 16'h0777;
    tick(K_NONE);
    check("t3_wa6", sram_bus.addr, 6);
    rec_addr = 20'd8; rec_data = 16'h0888;
    tick(K_STOP);
    check("t3_stop_we", sram_bus.we_n, 0);
    check("t3_stop_wa", sram_bus.addr, 7);
    check("t3_stop_st", state, S_IDLE);
    check("t3_end", end_addr, 7);

    // Playback data latency and hold while paused.
    play_addr = 20'd0; sram_bus.rdata = 16'hBEEF;
    tick(K_PLAY);
    tick(K_NONE);
    check("t5_pdata", play_data, 16'hBEEF);
    play_addr = 20'd1;
    tick(K_PAUSE);
    sram_bus.rdata = 16'h0000;
    tick(K_NONE);
    tick(K_REC);
    check("t5_hold", play_data, 16'hBEEF);
    check("t5_state", state, S_PP);
    check("t5_no_rec", rec_start, 0);
    tick(K_STOP);

    // Recording up to the last word.
    rec_addr = MAX_A - 20'd2;
    tick(K_REC);
    rec_addr = MAX_A - 20'd1;
    tick(K_NONE);
    rec_addr = MAX_A;
    tick(K_NONE);
    rec_addr = 20'd0; rec_data = 16'h5A5A;
    tick(K_NONE);
    check("t4_wa", sram_bus.addr, MAX_A);
    check("t4_stop", rec_stop, 1);
    check("t4_state", state, S_IDLE);
    check("t4_end", end_addr, MAX_A);
    tick(K_NONE);

    // Reset during a write strobe.
    rec_addr = 20'd10;
    tick(K_REC);
    rec_addr = 20'd11; rec_data = 16'hCAFE;
    tick(K_NONE);
    check("t6_we_pre", sram_bus.we_n, 0);
    i_rst = 1'b1;
    #1;
    check("t6_we_async", sram_bus.we_n, 1);
    check("t6_end", end_addr, 0);
    check("t6_state", state, S_IDLE);
    check("t6_oe", sram_bus.oe_n, 1);
    check("t6_addr", sram_bus.addr, 0);
    check("t6_wdata", sram_bus.wdata, 0);
    check("t6_pdata", play_data, 0);
    check("t6_pulses", pulses, 0);
    @(posedge i_clk);
    #1;
    rec_addr = '0; play_addr = '0;
    i_rst = 1'b0;
    model_reset();

    // Randomized sessions.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 39));
      case (r)
        0:       k = K_REC;
        1:       k = K_PLAY;
        2:       k = K_PAUSE;
        3:       k = K_STOP;
        4:       k = 4'($urandom);
        default: k = K_NONE;
      endcase
      if (m_state == S_IDLE) begin
        rec_addr  = '0;
        play_addr = '0;
      end else if (m_state == S_REC && $urandom_range(0, 2) == 0) begin
        rec_addr = rec_addr + 20'd1;
      end else if (m_state == S_RP && $urandom_range(0, 9) == 0) begin
        rec_addr = rec_addr + 20'd1;
      end
      if (m_state == S_PLAY && $urandom_range(0, 1) == 0) play_addr = play_addr + 20'd1;
      rec_data       = 16'($urandom);
      sram_bus.rdata = 16'($urandom);
      tick(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aud_session_ctrl.md
Name: aud_session_ctrl

Overview:
Top-level session controller for the audio lab datapath. It sequences the recorder and the player/DSP from debounced key pulses and owns the single SRAM port. It multiplexes that port between recorder writes and player reads. It also tracks the end-of-recording pointer that bounds playback.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, SRAM/sample word width
MAX_ADDR, 20'hFFFFF, last usable SRAM word address

Ports:
i_clk  in  1  system clock, all logic on posedge
i_rst  in  1  asynchronous reset, active-high
i_key_rec  in  1  one-cycle pulse: start/resume recording
i_key_play  in  1  one-cycle pulse: start/resume playback
i_key_pause  in  1  one-cycle pulse: pause current mode
i_key_stop  in  1  one-cycle pulse: stop current mode
i_rec_addr  in  ADDR_W  recorder current word address
i_rec_data  in  DATA_W  recorder completed word
i_play_addr  in  ADDR_W  player read address
i_sram_rdata  in  DATA_W  SRAM read data
o_rec_start / o_rec_pause / o_rec_stop  out  1 each  one-cycle pulses to recorder
o_play_start / o_play_pause / o_play_stop  out  1 each  one-cycle pulses to player
o_sram_addr  out  ADDR_W  SRAM address
o_sram_wdata  out  DATA_W  SRAM write data
o_sram_we_n  out  1  SRAM write enable, active-low
o_sram_oe_n  out  1  SRAM output enable, active-low
o_play_data  out  DATA_W  registered read data to player
o_end_addr  out  ADDR_W  last address written in most recent recording
o_state  out  3  current state code, for display

Behaviour:
- Reset values: state IDLE; all pulses 0; o_sram_we_n=1; o_sram_oe_n=1; o_sram_addr=0; o_sram_wdata=0; o_play_data=0; o_end_addr=0; internal rec_addr_q=0.
- States: IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4.
- Key priority when several keys arrive in the same cycle: stop > pause > rec > play.
- IDLE:
  - rec key -> REC. Pulse o_rec_start. Clear o_end_addr to 0. Load rec_addr_q from i_rec_addr.
  - play key with o_end_addr!=0 -> PLAY. Pulse o_play_start.
  - play key with o_end_addr==0 -> ignored, stay IDLE.
- REC:
  - pause key -> REC_PAUSE, pulse o_rec_pause.
  - stop key -> IDLE, pulse o_rec_stop.
- REC_PAUSE:
  - rec key -> REC, pulse o_rec_start.
  - stop key -> IDLE, pulse o_rec_stop.
- PLAY:
  - pause key -> PLAY_PAUSE, pulse o_play_pause.
  - stop key -> IDLE, pulse o_play_stop.
  - i_play_addr >= o_end_addr -> IDLE, pulse o_play_stop.
- PLAY_PAUSE:
  - play key -> PLAY, pulse o_play_start.
  - stop key -> IDLE, pulse o_play_stop.
- Cross-mode keys are ignored: rec/play key in PLAY*/REC* states, and pause in IDLE.
- Pulse timing: all command pulses are registered, high exactly 1 cycle, in the cycle after the key pulse.
- Write scheduling (REC only):
  - Each cycle, compare i_rec_addr with rec_addr_q.
  - On mismatch, next cycle drives o_sram_we_n=0 for exactly 1 cycle, o_sram_addr=rec_addr_q, o_sram_wdata=i_rec_data (sampled at detection).
  - On the same edge: o_end_addr<=rec_addr_q and rec_addr_q<=i_rec_addr.
- Address changes in REC_PAUSE: rec_addr_q tracks i_rec_addr with no write issued.
- Full memory: a write to MAX_ADDR also forces REC->IDLE with o_rec_stop, and o_end_addr=MAX_ADDR. The recorder's wrap to 0 is never written.
- Read path:
  - In PLAY/PLAY_PAUSE: o_sram_oe_n=0 and o_sram_addr=i_play_addr (combinational mux).
  - o_play_data<=i_sram_rdata every cycle in PLAY (1-cycle latency); held in PLAY_PAUSE.
- Idle port: in IDLE/REC_PAUSE, o_sram_addr=0 except during an in-flight write strobe, and oe_n=1.
- Write exclusivity: we_n and oe_n are never low simultaneously.
- Reset mid-write: we_n returns to 1 immediately (asynchronous). o_end_addr clears to 0, so the recording is lost by design.
- Stop in the same cycle as an address-change detection: the pending write still completes (1 cycle), then the state is IDLE.

Decomposition:
- Package aud_pkg holds:
  - state enum (3-bit encoding above);
  - ADDR_W/DATA_W defaults and MAX_ADDR;
  - key-priority helper function.
- One sub-module, aud_sram_mux. It covers address-change detection, the write-strobe register and the address/oe/we multiplexing. It is controlled by a mode input from the FSM.

Test Plan:
- Reset, then rec key; i_rec_addr steps 0->1->2, i_rec_data=16'hA5A5 then 16'h1234; then stop. Expected: o_rec_start 1 cycle; two we_n strobes at addr 0 (A5A5) and addr 1 (1234); o_rec_stop; o_end_addr=1; state IDLE.
- Play key with o_end_addr=0 -> no o_play_start, state stays 0. After a recording with end=1: play -> o_play_start, oe_n=0. i_play_addr=1 -> o_play_stop next cycle, state IDLE.
- In REC, pause+stop in the same cycle -> only o_rec_stop. In REC_PAUSE, i_rec_addr changes 5->6 -> no write strobe. Rec key -> o_rec_start, back to REC.
- Recording reaches MAX_ADDR: address change 20'hFFFFF->0 -> write at 20'hFFFFF, o_rec_stop, o_end_addr=20'hFFFFF, state IDLE.
- Play with i_sram_rdata=16'hBEEF -> o_play_data=16'hBEEF one cycle later. Pause -> o_play_data holds while rdata changes to 16'h0000. Rec key in PLAY_PAUSE ignored.
- Assert i_rst during a we_n=0 cycle -> we_n=1 without waiting for a clock edge; all outputs at reset values; o_end_addr=0.
